// File: rtl/asyncio_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// asyncio_mem_arbiter_pkg
// Shared asyncio definitions used by the memory arbiter and by the asyncio
// reader/writer clients.
//   `ADDRESS_WIDTH : width of every address bus in the asyncio family
//   `LENGTH_WIDTH  : width of transfer-length fields in the reader/writer
//   DATA_WIDTH     : width of one memory word
//   arb_state_t    : arbiter FSM state encoding (IDLE -> ISSUE -> DONE)
// No ports; compile this file before any file that imports the package.
// ---------------------------------------------------------------------------
`ifndef ASYNCIO_DEFINES_SVH
`define ASYNCIO_DEFINES_SVH
`define ADDRESS_WIDTH 32
`define LENGTH_WIDTH 16
`endif

package asyncio_mem_arbiter_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/asyncio_mem_arbiter_rr_select.sv
// ---------------------------------------------------------------------------
// rr_select
// Purely combinational round-robin picker. The search starts at the client
// after last_grant and wraps, so the client served most recently has the
// lowest priority.
//   req        in  NO_OF_REQUESTERS  request vector
//   last_grant in  ID_WIDTH          index of the most recently served client
//   grant      out ID_WIDTH          chosen client (0 when nothing requested)
//   found      out 1                 at least one request bit was set
// ---------------------------------------------------------------------------
module rr_select #(
    parameter int NO_OF_REQUESTERS = 2,
    parameter int ID_WIDTH         = 1
) (
    input  logic [NO_OF_REQUESTERS-1:0] req,
    input  logic [ID_WIDTH-1:0]         last_grant,
    output logic [ID_WIDTH-1:0]         grant,
    output logic                        found
);

    // Walk the offsets 1..N from last_grant; the first requesting client wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 1; k <= NO_OF_REQUESTERS; k++) begin
            for (int i = 0; i < NO_OF_REQUESTERS; i++) begin
                if (!found && req[i] &&
                    (((int'(last_grant) + k) % NO_OF_REQUESTERS) == i)) begin
                    found = 1'b1;
                    grant = ID_WIDTH'(i);
                end
            end
        end
    end

endmodule

// File: rtl/asyncio_mem_arbiter.sv
// ---------------------------------------------------------------------------
// asyncio_mem_arbiter
// Shares one memory port between NO_OF_REQUESTERS asyncio clients using a
// round-robin IDLE -> ISSUE -> DONE handshake. All outputs are registered.
//   clk, rst                     clock, synchronous active-high reset
//   req_enable/req_write         per-client request and type (1 = store)
//   req_address/req_wdata        per-client address/data, client i in slice i
//   req_ready                    one-cycle completion pulse to the owner
//   req_rdata                    last load result, shared by all clients
//   mem_enable/mem_write         downstream request and type
//   mem_address/mem_wdata        downstream address and store data
//   mem_ready/mem_rdata          downstream completion and load data
//   busy/grant_id                transaction in flight / owning client
// ---------------------------------------------------------------------------
module asyncio_mem_arbiter
    import asyncio_mem_arbiter_pkg::*;
#(
    parameter int NO_OF_REQUESTERS = 2,
    parameter int ID_WIDTH         = 1
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NO_OF_REQUESTERS-1:0]              req_enable,
    input  logic [NO_OF_REQUESTERS-1:0]              req_write,
    input  logic [NO_OF_REQUESTERS*`ADDRESS_WIDTH-1:0] req_address,
    input  logic [NO_OF_REQUESTERS*DATA_WIDTH-1:0]   req_wdata,
    output logic [NO_OF_REQUESTERS-1:0]              req_ready,
    output logic [DATA_WIDTH-1:0]                    req_rdata,
    output logic                                     mem_enable,
    output logic                                     mem_write,
    output logic [`ADDRESS_WIDTH-1:0]                mem_address,
    output logic [DATA_WIDTH-1:0]                    mem_wdata,
    input  logic                                     mem_ready,
    input  logic [DATA_WIDTH-1:0]                    mem_rdata,
    output logic                                     busy,
    output logic [ID_WIDTH-1:0]                      grant_id
);

    arb_state_t                    state;
    arb_state_t                    next_state;
    logic [ID_WIDTH-1:0]           last_grant;
    logic [ID_WIDTH-1:0]           sel_grant;
    logic                          sel_found;
    logic [NO_OF_REQUESTERS-1:0]   grant_onehot;
    logic [`ADDRESS_WIDTH-1:0]     client_addr [NO_OF_REQUESTERS];
    logic [DATA_WIDTH-1:0]         client_wdata [NO_OF_REQUESTERS];

    rr_select #(
        .NO_OF_REQUESTERS (NO_OF_REQUESTERS),
        .ID_WIDTH         (ID_WIDTH)
    ) u_rr_select (
        .req        (req_enable),
        .last_grant (last_grant),
        .grant      (sel_grant),
        .found      (sel_found)
    );

    // Unpack the flat client buses so the winner can be picked by index.
    always_comb begin
        for (int i = 0; i < NO_OF_REQUESTERS; i++) begin
            client_addr[i]  = req_address[i*`ADDRESS_WIDTH +: `ADDRESS_WIDTH];
            client_wdata[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // One-hot of the current owner, used to aim the req_ready pulse.
    always_comb begin
        grant_onehot = '0;
        for (int i = 0; i < NO_OF_REQUESTERS; i++) begin
            grant_onehot[i] = (grant_id == ID_WIDTH'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // DONE never looks at req_enable: that one-cycle gap lets a registered
    // client drop its enable before the next arbitration round.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (sel_found) next_state = ST_ISSUE;
            ST_ISSUE: if (mem_ready) next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Output registers. The winner's request is frozen at grant time so the
    // client may change or drop its inputs while the memory is busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_enable  <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            req_ready   <= '0;
            req_rdata   <= '0;
            grant_id    <= '0;
            last_grant  <= ID_WIDTH'(NO_OF_REQUESTERS - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    req_ready <= '0;
                    if (sel_found) begin
                        grant_id    <= sel_grant;
                        mem_enable  <= 1'b1;
                        mem_write   <= req_write[sel_grant];
                        mem_address <= client_addr[sel_grant];
                        mem_wdata   <= client_wdata[sel_grant];
                    end
                end
                ST_ISSUE: begin
                    if (mem_ready) begin
                        mem_enable <= 1'b0;
                        req_ready  <= grant_onehot;
                        last_grant <= grant_id;
                        if (!mem_write) begin
                            req_rdata <= mem_rdata;
                        end
                    end
                end
                ST_DONE: begin
                    req_ready <= '0;
                end
                default: begin
                    mem_enable <= 1'b0;
                    req_ready  <= '0;
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_asyncio_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_asyncio_mem_arbiter
// Scenario bench for the two-client memory arbiter. A memory responder
// answers after a programmable number of ISSUE cycles and logs every
// completed handshake; each scenario task compares what it sees against a
// round-robin reference kept as a plain "last served client" integer.
// ---------------------------------------------------------------------------
module tb_asyncio_mem_arbiter;

    localparam int N   = 2;
    localparam int IDW = 1;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_enable;
    logic [N-1:0]      req_write;
    logic [N*32-1:0]   req_address;
    logic [N*32-1:0]   req_wdata;
    logic [N-1:0]      req_ready;
    logic [31:0]       req_rdata;
    logic              mem_enable;
    logic              mem_write;
    logic [31:0]       mem_address;
    logic [31:0]       mem_wdata;
    logic              mem_ready;
    logic [31:0]       mem_rdata;
    logic              busy;
    logic [IDW-1:0]    grant_id;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] addr_c  [N];
    logic [31:0] wdata_c [N];

    // Reference model state: the client that was served last.
    int ref_last = N - 1;

    // Memory responder controls and transaction log.
    int          mem_lat    = 1;
    int          issue_cnt  = 0;
    logic [31:0] next_rdata = 32'h0;
    logic [31:0] log_addr  [$];
    logic [31:0] log_wdata [$];
    logic        log_write [$];
    int          log_grant [$];

    asyncio_mem_arbiter #(
        .NO_OF_REQUESTERS (N),
        .ID_WIDTH         (IDW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_enable  (req_enable),
        .req_write   (req_write),
        .req_address (req_address),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .req_rdata   (req_rdata),
        .mem_enable  (mem_enable),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .busy        (busy),
        .grant_id    (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responder works on the falling edge; a ready raised here is taken at the
    // next rising edge unless reset is active, so that is when it is logged.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_enable === 1'b1 && rst === 1'b0) begin
                issue_cnt++;
                if (issue_cnt >= mem_lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = next_rdata;
                    log_addr.push_back(mem_address);
                    log_wdata.push_back(mem_wdata);
                    log_write.push_back(mem_write);
                    log_grant.push_back(int'(grant_id));
                end else begin
                    mem_ready = 1'b0;
                end
            end else begin
                issue_cnt = 0;
                mem_ready = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int rr_pick(input logic [N-1:0] en, input int last);
        for (int k = 1; k <= N; k++) begin
            if (((int'(en) >> ((last + k) % N)) & 1) != 0) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bus();
        req_address = {addr_c[1], addr_c[0]};
        req_wdata   = {wdata_c[1], wdata_c[0]};
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_wdata.delete();
        log_write.delete();
        log_grant.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_enable = '0;
        tick();
        tick();
        n_cmp++;
        if (mem_enable !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL reset_mem_enable: got %b expected 0", mem_enable);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL reset_busy: got %b expected 0", busy);
        end
        n_cmp++;
        if (req_ready !== 2'b00 || grant_id !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL reset_ready_grant: got ready=%b grant=%b expected 00/0", req_ready, grant_id);
        end
        n_cmp++;
        if ({mem_write, mem_address, mem_wdata, req_rdata} !== 97'h0) begin
            n_bad++;
            $display("[TB] FAIL reset_data_regs: got wr=%b a=%h d=%h r=%h expected all 0",
                     mem_write, mem_address, mem_wdata, req_rdata);
        end
        rst = 1'b0;
        ref_last = N - 1;
        clear_log();
    endtask

    task automatic test_single_store();
        int          en_cycles = 0;
        int          pulses    = 0;
        int          cyc       = 0;
        bit          bus_ok    = 1'b1;
        bit          done      = 1'b0;
        logic [1:0]  ready_val = 2'b00;
        mem_lat = 2;
        clear_log();
        addr_c[0] = 32'd4;
        wdata_c[0] = 32'd7;
        drive_bus();
        req_write  = 2'b01;
        req_enable = 2'b01;
        while (!done && cyc < 40) begin
            tick();
            cyc++;
            if (mem_enable === 1'b1) begin
                en_cycles++;
                if (mem_address !== 32'd4 || mem_wdata !== 32'd7 || mem_write !== 1'b1) bus_ok = 1'b0;
            end
            if (req_ready !== 2'b00) begin
                pulses++;
                ready_val  = req_ready;
                req_enable = 2'b00;
            end else if (pulses > 0) begin
                done = 1'b1;
            end
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("[TB] FAIL single_timeout: got no completion in %0d cycles, expected one", cyc);
        end
        n_cmp++;
        if (en_cycles != 2) begin
            n_bad++;
            $display("[TB] FAIL single_enable_cycles: got %0d expected 2", en_cycles);
        end
        n_cmp++;
        if (!bus_ok) begin
            n_bad++;
            $display("[TB] FAIL single_bus: got bad address/data/type during ISSUE, expected 4/7/store");
        end
        n_cmp++;
        if (pulses != 1 || ready_val !== 2'b01) begin
            n_bad++;
            $display("[TB] FAIL single_ready: got %0d pulses val=%b expected 1 pulse 01", pulses, ready_val);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL single_idle_after: got busy=%b expected 0", busy);
        end
        n_cmp++;
        if (log_addr.size() != 1) begin
            n_bad++;
            $display("[TB] FAIL single_txn_count: got %0d expected 1", log_addr.size());
        end
        ref_last = 0;
    endtask

    task automatic test_contention();
        int got  = 0;
        int cyc  = 0;
        int prev = -1;
        int exp_g;
        clear_log();
        for (int i = 0; i < N; i++) begin
            addr_c[i]  = $urandom;
            wdata_c[i] = $urandom;
        end
        drive_bus();
        req_write  = 2'($urandom_range(0, 3));
        mem_lat    = $urandom_range(1, 3);
        req_enable = 2'b11;
        while (got < 4 && cyc < 200) begin
            tick();
            cyc++;
            if (req_ready !== 2'b00) begin
                exp_g = rr_pick(2'b11, ref_last);
                n_cmp++;
                if (req_ready !== (2'b01 << exp_g) || int'(grant_id) != exp_g) begin
                    n_bad++;
                    $display("[TB] FAIL contention_grant: got ready=%b id=%0d expected client %0d",
                             req_ready, grant_id, exp_g);
                end
                n_cmp++;
                if (int'(grant_id) == prev) begin
                    n_bad++;
                    $display("[TB] FAIL contention_repeat: got client %0d twice, expected alternation", prev);
                end
                n_cmp++;
                if (log_addr.size() != got + 1 || log_addr[log_addr.size()-1] !== addr_c[exp_g]
                    || log_wdata[log_wdata.size()-1] !== wdata_c[exp_g]
                    || log_write[log_write.size()-1] !== req_write[exp_g]) begin
                    n_bad++;
                    $display("[TB] FAIL contention_bus: got %0d txns last a=%h expected %0d txns a=%h",
                             log_addr.size(), (log_addr.size() > 0) ? log_addr[log_addr.size()-1] : 32'h0,
                             got + 1, addr_c[exp_g]);
                end
                prev     = int'(grant_id);
                ref_last = exp_g;
                got++;
                mem_lat  = $urandom_range(1, 3);
                if (got == 4) req_enable = 2'b00;
            end
        end
        n_cmp++;
        if (got != 4) begin
            n_bad++;
            $display("[TB] FAIL contention_timeout: got %0d grants expected 4", got);
        end
        tick();
    endtask

    task automatic test_load();
        int  cyc    = 0;
        bit  seen   = 1'b0;
        int  stray  = 0;
        clear_log();
        next_rdata = 32'hDEADBEEF;
        mem_lat    = $urandom_range(1, 3);
        addr_c[1]  = $urandom;
        drive_bus();
        req_write  = 2'b00;
        req_enable = 2'b10;
        while (!seen && cyc < 40) begin
            tick();
            cyc++;
            if (req_ready[0] !== 1'b0) stray++;
            if (req_ready !== 2'b00) begin
                seen = 1'b1;
                req_enable = 2'b00;
                n_cmp++;
                if (req_ready !== 2'b10 || req_rdata !== 32'hDEADBEEF) begin
                    n_bad++;
                    $display("[TB] FAIL load_result: got ready=%b rdata=%h expected 10/deadbeef",
                             req_ready, req_rdata);
                end
            end
        end
        n_cmp++;
        if (!seen || stray != 0) begin
            n_bad++;
            $display("[TB] FAIL load_handshake: got seen=%0d stray0=%0d expected 1/0", seen, stray);
        end
        ref_last = 1;
        // A following store must leave the load result untouched.
        next_rdata = $urandom;
        addr_c[0]  = $urandom;
        wdata_c[0] = $urandom;
        drive_bus();
        req_write  = 2'b01;
        req_enable = 2'b01;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 40) begin
            tick();
            cyc++;
            if (req_ready !== 2'b00) begin
                seen = 1'b1;
                req_enable = 2'b00;
            end
        end
        n_cmp++;
        if (!seen || req_rdata !== 32'hDEADBEEF) begin
            n_bad++;
            $display("[TB] FAIL load_hold: got seen=%0d rdata=%h expected 1/deadbeef", seen, req_rdata);
        end
        ref_last = 0;
        tick();
    endtask

    task automatic test_stall();
        logic [31:0] a0;
        logic [31:0] w0;
        int          cyc  = 0;
        bit          seen = 1'b0;
        clear_log();
        mem_lat    = 11;
        addr_c[0]  = $urandom;
        wdata_c[0] = $urandom;
        a0 = addr_c[0];
        w0 = wdata_c[0];
        drive_bus();
        req_write  = 2'b01;
        req_enable = 2'b01;
        while (mem_enable !== 1'b1 && cyc < 10) begin
            tick();
            cyc++;
        end
        for (int c = 0; c < 10; c++) begin
            addr_c[0]  = $urandom;
            wdata_c[0] = $urandom;
            drive_bus();
            req_write[0] = ~req_write[0];
            if (c == 4) req_enable = 2'b00;
            tick();
            n_cmp++;
            if (mem_address !== a0 || mem_wdata !== w0 || mem_write !== 1'b1
                || busy !== 1'b1 || mem_enable !== 1'b1 || req_ready !== 2'b00) begin
                n_bad++;
                $display("[TB] FAIL stall_cycle%0d: got a=%h d=%h wr=%b busy=%b en=%b rdy=%b expected a=%h d=%h 1 1 1 00",
                         c, mem_address, mem_wdata, mem_write, busy, mem_enable, req_ready, a0, w0);
            end
        end
        cyc = 0;
        while (!seen && cyc < 20) begin
            tick();
            cyc++;
            if (req_ready !== 2'b00) seen = 1'b1;
        end
        n_cmp++;
        if (!seen || log_addr.size() != 1 || log_addr[0] !== a0) begin
            n_bad++;
            $display("[TB] FAIL stall_complete: got seen=%0d txns=%0d expected 1/1 at %h",
                     seen, log_addr.size(), a0);
        end
        req_write = 2'b00;
        ref_last = 0;
        tick();
    endtask

    task automatic test_reset_mid_issue();
        int cyc  = 0;
        bit seen = 1'b0;
        int exp_g;
        clear_log();
        mem_lat    = 20;
        req_enable = 2'b11;
        while (mem_enable !== 1'b1 && cyc < 10) begin
            tick();
            cyc++;
        end
        exp_g = rr_pick(2'b11, ref_last);
        n_cmp++;
        if (int'(grant_id) != exp_g) begin
            n_bad++;
            $display("[TB] FAIL rstmid_pre_grant: got %0d expected %0d", grant_id, exp_g);
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({mem_enable, busy, req_ready, grant_id, mem_write} !== 6'b0
            || {mem_address, mem_wdata, req_rdata} !== 96'h0) begin
            n_bad++;
            $display("[TB] FAIL rstmid_outputs: got en=%b busy=%b rdy=%b id=%b a=%h r=%h expected all 0",
                     mem_enable, busy, req_ready, grant_id, mem_address, req_rdata);
        end
        rst = 1'b0;
        ref_last = N - 1;
        mem_lat  = 1;
        cyc = 0;
        while (!seen && cyc < 40) begin
            tick();
            cyc++;
            if (req_ready !== 2'b00) begin
                seen = 1'b1;
                req_enable = 2'b00;
                exp_g = rr_pick(2'b11, ref_last);
                n_cmp++;
                if (req_ready !== (2'b01 << exp_g) || log_addr.size() != 1) begin
                    n_bad++;
                    $display("[TB] FAIL rstmid_next_grant: got ready=%b txns=%0d expected client %0d, 1 txn",
                             req_ready, log_addr.size(), exp_g);
                end
                ref_last = exp_g;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("[TB] FAIL rstmid_timeout: got no grant after reset, expected one");
        end
        tick();
    endtask

    task automatic test_once_only();
        logic [31:0] exp_addr [5];
        int          pulses = 0;
        int          bad_addr = 0;
        clear_log();
        req_write = 2'b01;
        for (int w = 0; w < 5; w++) begin
            int cyc  = 0;
            bit seen = 1'b0;
            addr_c[0]   = $urandom;
            wdata_c[0]  = $urandom;
            exp_addr[w] = addr_c[0];
            drive_bus();
            mem_lat    = $urandom_range(1, 4);
            req_enable = 2'b01;
            while (!seen && cyc < 30) begin
                tick();
                cyc++;
                if (req_ready !== 2'b00) begin
                    seen = 1'b1;
                    pulses++;
                end
            end
            // Client registers req_ready, so its enable drops one cycle late.
            tick();
            n_cmp++;
            if (busy !== 1'b0 || mem_enable !== 1'b0) begin
                n_bad++;
                $display("[TB] FAIL once_regrant_w%0d: got busy=%b en=%b expected 0/0", w, busy, mem_enable);
            end
            req_enable = 2'b00;
            tick();
        end
        tick();
        tick();
        for (int w = 0; w < 5; w++) begin
            if (w < log_addr.size() && log_addr[w] !== exp_addr[w]) bad_addr++;
        end
        n_cmp++;
        if (log_addr.size() != 5 || pulses != 5 || bad_addr != 0) begin
            n_bad++;
            $display("[TB] FAIL once_count: got txns=%0d pulses=%0d badaddr=%0d expected 5/5/0",
                     log_addr.size(), pulses, bad_addr);
        end
        ref_last = 0;
    endtask

    initial begin
        rst        = 1'b1;
        req_enable = '0;
        req_write  = '0;
        for (int i = 0; i < N; i++) begin
            addr_c[i]  = 32'h0;
            wdata_c[i] = 32'h0;
        end
        drive_bus();
        test_reset();
        test_single_store();
        test_contention();
        test_load();
        test_stall();
        test_reset_mid_issue();
        test_once_only();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/asyncio_mem_arbiter.md
ASYNCIO_MEM_ARBITER -- requirements
Module: asyncio_mem_arbiter

Interface
REQ-001 SHALL have parameter NO_OF_REQUESTERS, default 2, the number of asyncio reader/writer clients sharing one memory port (range 1..8).
REQ-002 SHALL have parameter ID_WIDTH, default 1, the width of grant_id; must satisfy 2**ID_WIDTH >= NO_OF_REQUESTERS.
REQ-003 SHALL use `ADDRESS_WIDTH (32) for all address ports.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 req_enable  input  NO_OF_REQUESTERS  per-client memory_op_enable.
REQ-007 req_write  input  NO_OF_REQUESTERS  per-client op type: 1 = store, 0 = load.
REQ-008 req_address  input  NO_OF_REQUESTERS*`ADDRESS_WIDTH  per-client address; client i at bits [(i+1)*32-1 : i*32].
REQ-009 req_wdata  input  NO_OF_REQUESTERS*32  per-client word_to_store; same packing as req_address.
REQ-010 req_ready  output  NO_OF_REQUESTERS  per-client memory_op_ready, one-hot or zero.
REQ-011 req_rdata  output  32  load result, shared by all clients.
REQ-012 mem_enable, mem_write  output  1 each  downstream request and type.
REQ-013 mem_address  output  `ADDRESS_WIDTH, mem_wdata  output  32  downstream address and store data.
REQ-014 mem_ready  input  1, mem_rdata  input  32  downstream completion and load data, valid when mem_ready=1.
REQ-015 busy  output  1, grant_id  output  ID_WIDTH  status: transaction in flight and owning client.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, ISSUE, DONE.
REQ-017 IDLE: if any req_enable bit is 1, select a client by round-robin, latch its write/address/wdata into output registers, set grant_id, and go to ISSUE; otherwise stay.
REQ-018 Round-robin: search starts at (last_grant+1) mod NO_OF_REQUESTERS and wraps; last_grant resets to NO_OF_REQUESTERS-1, so client 0 has first priority.
REQ-019 ISSUE: mem_enable=1 with latched, stable signals; on mem_ready=1 capture mem_rdata into req_rdata, update last_grant, go to DONE. Minimum handshake latency is 1 cycle in ISSUE.
REQ-020 DONE: req_ready[grant_id]=1 for exactly one cycle, mem_enable=0; unconditionally go to IDLE.
REQ-021 The arbiter SHALL NOT sample req_enable in DONE, so a registered client drops enable before re-arbitration and each word is transferred only once.
REQ-022 req_ready bits of non-granted clients SHALL be 0 at all times; req_rdata holds its value until the next load completes.
REQ-023 Changes to a client's inputs during ISSUE SHALL NOT affect mem_address/mem_wdata/mem_write.
REQ-024 A client dropping req_enable during its own ISSUE SHALL NOT abort the transaction; the arbiter completes it.
REQ-025 busy = (state != IDLE); grant_id holds the last granted value in IDLE.
REQ-026 All outputs SHALL be driven from registers; there is no combinational path from req_* or mem_ready to any output.

Reset
REQ-027 On rst=1 at a clock edge: state=IDLE, mem_enable=0, mem_write=0, mem_address=0, mem_wdata=0, req_ready=0, req_rdata=0, grant_id=0, busy=0, last_grant=NO_OF_REQUESTERS-1.
REQ-028 Reset during ISSUE or DONE SHALL abandon the transaction with no req_ready pulse; mem_enable is 0 in the cycle after the reset edge.

Structure
REQ-029 FSM state encodings and the `ADDRESS_WIDTH/`LENGTH_WIDTH defines SHALL live in the shared asyncio include, common with asyncio_reader/asyncio_writer.
REQ-030 The round-robin selector (req vector + last_grant -> grant index + found flag) SHALL be one combinational sub-module, rr_select.

Verification
REQ-031 Single client: client 0 store at addr 4, data 7; mem_ready after 2 cycles -> mem_enable high 2 cycles, mem_address=4, mem_wdata=7, req_ready[0] pulses 1 cycle, then IDLE.
REQ-032 Contention: both clients hold enable for 4 back-to-back transactions -> grants alternate 0,1,0,1; never two consecutive grants to one client.
REQ-033 Load: client 1 load, mem_rdata=0xDEADBEEF with mem_ready -> req_rdata=0xDEADBEEF in the req_ready[1] cycle; req_ready[0] stays 0.
REQ-034 Stall: mem_ready held 0 for 10 cycles while client changes req_address -> mem_address unchanged, busy=1 throughout.
REQ-035 Reset mid-ISSUE: assert rst for 1 cycle -> all outputs at reset values next cycle, no req_ready pulse, next grant goes to client 0.
REQ-036 Once-only: client holds enable 1 cycle past req_ready (registered drop) -> exactly one memory transaction per word, counted over 5 words.
